// File: rtl/fsm_switch_conditioner.sv
// Conditions the four raw slide switches feeding the vacuum-cleaner FSM:
// two-flop synchronizer, per-bit debounce, fixed-priority one-hot resolve.
module fsm_switch_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_raw,
   output logic       power_off_o,
   output logic       on_o,
   output logic       cleaning_o,
   output logic       evading_o,
   output logic       cmd_valid,
   output logic [3:0] sw_stable
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [3:0]       s1_q, s1_d;
   logic [3:0]       s2_q, s2_d;
   logic [3:0]       stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       cmd_q, cmd_d;
   logic [3:0]       cmd_prev_q, cmd_prev_d;
   logic             cmd_valid_q, cmd_valid_d;

   // Synchronizer and per-bit debounce: a counter only runs while the
   // synchronized level disagrees with the accepted one, so any agreeing
   // sample discards a partial count.
   always_comb begin
      s1_d     = sw_raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         // NOTE: every comb output gets a default before any branch, so no latch is inferred.
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // Priority power_off > evading > cleaning > on; result is one-hot or zero.
   always_comb begin
      cmd_d = 4'b0000;
      if (stable_q[0]) begin
         cmd_d = 4'b0001;
      end else if (stable_q[3]) begin
         cmd_d = 4'b1000;
      end else if (stable_q[2]) begin
         cmd_d = 4'b0100;
      end else if (stable_q[1]) begin
         cmd_d = 4'b0010;
      end
      cmd_prev_d  = cmd_q;
      cmd_valid_d = (cmd_q != cmd_prev_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         stable_q    <= '0;
         cmd_q       <= '0;
         cmd_prev_q  <= '0;
         cmd_valid_q <= 1'b0;
         // NOTE: the counter array is cleared explicitly; a count interrupted by reset must not survive it.
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         stable_q    <= stable_d;
         cmd_q       <= cmd_d;
         cmd_prev_q  <= cmd_prev_d;
         cmd_valid_q <= cmd_valid_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign power_off_o = cmd_q[0];
   assign on_o        = cmd_q[1];
   assign cleaning_o  = cmd_q[2];
   assign evading_o   = cmd_q[3];
   assign cmd_valid   = cmd_valid_q;
   assign sw_stable   = stable_q;

endmodule

// File: doc/fsm_switch_conditioner.md
# fsm_switch_conditioner

Input-conditioning stage directly upstream of the vacuum-cleaner Moore FSM. Takes the four raw slide switches (power_off, on, cleaning, evading) from `ui_in[3:0]` and synchronises, debounces and priority-resolves them. Delivers at most one asserted command level to the FSM, plus a one-cycle strobe whenever the resolved command changes. The FSM's command inputs must be driven only from this block, never from raw pads.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a new switch level. Legal range 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each debounce counter. Derived; never overridden.

Ports:
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sw_raw`  in  4: asynchronous switch levels.
  - bit0 = power_off
  - bit1 = on
  - bit2 = cleaning
  - bit3 = evading
- `power_off_o`  out  1: resolved command, registered.
- `on_o`  out  1: resolved command, registered.
- `cleaning_o`  out  1: resolved command, registered.
- `evading_o`  out  1: resolved command, registered.
- `cmd_valid`  out  1: one-cycle pulse when the resolved 4-bit command vector changes.
- `sw_stable`  out  4: debounced per-switch levels before priority resolution, for observation and test.

## Operation

- Synchronizer: two flops per bit, `s1 <= sw_raw` and `s2 <= s1`. Only `s2` is used downstream.
- Debouncer, per bit i, with registers `stable[i]` and `cnt[i]`:
  - If `s2[i] == stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` consecutive mismatching samples is discarded and the counter restarts from 0.
  - The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- Priority resolver, combinational from `stable`, fixed order power_off > evading > cleaning > on:
  - `stable[0]=1` gives 0001.
  - else `stable[3]` gives 1000.
  - else `stable[2]` gives 0100.
  - else `stable[1]` gives 0010.
  - else 0000.
  - The result is registered into `{evading_o, cleaning_o, on_o, power_off_o}`, so the output vector is always one-hot or zero.
- `cmd_valid` is registered. It is 1 in the cycle immediately after the output vector register takes a value different from its previous value, and 0 otherwise. A change to 0000 also strobes.
- Reset: when `rst`=1 on a clock edge, the following are all cleared to 0:
  - `s1`, `s2`, `stable`, every `cnt`
  - all four command outputs
  - `cmd_valid`
  - `sw_stable` (= `stable`)
- Reset has priority over every other update. Reset asserted mid-count abandons the count. Switches held high through reset are re-accepted only after the full synchronizer plus debounce latency following reset release.

## Timing

- Raw edge sampled at edge k: `s1` at k, `s2` at k+1. The first mismatch is counted at edge k+2.
- `stable` changes at edge k+1+`DEBOUNCE_CYCLES`.
- Command outputs change at edge k+2+`DEBOUNCE_CYCLES`.
- `cmd_valid` is high for the cycle following edge k+3+`DEBOUNCE_CYCLES`, exactly one cycle.
- Total raw-to-command latency is `DEBOUNCE_CYCLES`+2 edges after the sampling edge.
- Simultaneous changes on several switches are debounced independently. Bits that settle on the same edge produce a single resolved change and a single `cmd_valid`.
- A change on a lower-priority switch while a higher one is stable high alters `sw_stable` only. It does not change the outputs and does not strobe `cmd_valid`.
- Back-to-back resolved changes on consecutive cycles produce back-to-back `cmd_valid` pulses, one per change.
- `cmd_valid` is never held high for two cycles on a single change.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- Reset: assert `rst` for 2 cycles with `sw_raw`=1111. Required response: all outputs 0 throughout reset. After release, `power_off_o`=1 exactly 6 edges after the first post-reset sampling edge, with one `cmd_valid` pulse and `sw_stable`=1111.
- Clean press: with `sw_raw` 0000 settled, drive 0010. Required response: `on_o` rises 6 edges later, `cmd_valid` pulses once, and no other output toggles.
- Glitch rejection: with 0000 settled, drive `sw_raw[2]` high for 3 cycles, then low. Required response: `sw_stable` stays 0000, `cleaning_o` stays 0, and no `cmd_valid` occurs. Repeat with a 5-cycle high: `cleaning_o` pulses, with two `cmd_valid` pulses (rise and fall).
- Priority: settle 0110, giving `cleaning_o`=1. Then raise bit3: `evading_o`=1, `cleaning_o`=0, one `cmd_valid`. Then raise bit0: `power_off_o`=1 only. Drop bit1 while bit0 is high: outputs unchanged, no `cmd_valid`, `sw_stable[1]`=0.
- Simultaneous release: from 1100 settled (`evading_o`=1), drive 0000 on one edge. Required response: a single transition to 0000 and exactly one `cmd_valid`.
- Reset mid-count: drive 0100, assert `rst` after 3 debounce cycles, release, and keep 0100. Required response: `cleaning_o` asserts only after the full 6-edge latency measured from reset release.
